// File: rtl/fetch_hazard_controller.sv
// Fetch-stage sequencer: resolves load-use hazards, external holds and taken
// branches into Stall / PCsrc / inMux / IDEXBubble, with saturating perf counters.
module fetch_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDusesRt,
  input  logic             EXMemRead,
  input  logic [4:0]       EXrt,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             HoldReq,
  output logic             Stall,
  output logic             PCsrc,
  output logic [31:0]      inMux,
  output logic             IDEXBubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LUSTALL  = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_luhit;
  logic             w_stall;
  logic             w_pcsrc;
  logic             w_bubble;
  logic [31:0]      w_inmux;

  assign w_luhit = EXMemRead && (EXrt != 5'd0) &&
                   ((EXrt == IDrs) || (IDusesRt && (EXrt == IDrt)));

  // Hazard only honoured from RUN: this caps a load-use stall at one cycle and
  // keeps the zeroed instruction after a redirect from raising a false hit.
  always_comb begin
    w_next   = ST_RUN;
    w_stall  = 1'b0;
    w_pcsrc  = 1'b0;
    w_bubble = 1'b0;
    w_inmux  = 32'd0;
    if (RST) begin
      w_next = ST_RUN;
    end else if (BranchTaken) begin
      w_pcsrc  = 1'b1;
      w_inmux  = BranchTarget;
      w_bubble = 1'b1;
      w_next   = ST_REDIRECT;
    end else if (HoldReq) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      w_next   = ST_HOLD;
    end else if (w_luhit && (r_state == ST_RUN)) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      w_next   = ST_LUSTALL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_pcsrc && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Every output reads as zero while reset is held.
  assign Stall      = w_stall;
  assign PCsrc      = w_pcsrc;
  assign inMux      = w_inmux;
  assign IDEXBubble = w_bubble;
  assign StallCount = RST ? '0 : r_stall_cnt;
  assign FlushCount = RST ? '0 : r_flush_cnt;
  assign State      = RST ? 2'd0 : r_state;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed bench for fetch_hazard_controller: each vector queues its expected
// outputs, and a monitor pops and compares them mid-cycle.
module tb_fetch_hazard_controller;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        hold_req;

  logic        stall;
  logic        pcsrc;
  logic [31:0] in_mux;
  logic        bubble;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  state;

  logic        stall4;
  logic        pcsrc4;
  logic [31:0] in_mux4;
  logic        bubble4;
  logic [3:0]  stall_cnt4;
  logic [3:0]  flush_cnt4;
  logic [1:0]  state4;

  fetch_hazard_controller #(.CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .IDrs(id_rs), .IDrt(id_rt), .IDusesRt(id_uses_rt),
    .EXMemRead(ex_mem_read), .EXrt(ex_rt), .BranchTaken(branch_taken),
    .BranchTarget(branch_target), .HoldReq(hold_req), .Stall(stall),
    .PCsrc(pcsrc), .inMux(in_mux), .IDEXBubble(bubble), .StallCount(stall_cnt),
    .FlushCount(flush_cnt), .State(state)
  );

  fetch_hazard_controller #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .IDrs(id_rs), .IDrt(id_rt), .IDusesRt(id_uses_rt),
    .EXMemRead(ex_mem_read), .EXrt(ex_rt), .BranchTaken(branch_taken),
    .BranchTarget(branch_target), .HoldReq(hold_req), .Stall(stall4),
    .PCsrc(pcsrc4), .inMux(in_mux4), .IDEXBubble(bubble4), .StallCount(stall_cnt4),
    .FlushCount(flush_cnt4), .State(state4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        pcsrc;
    logic [31:0] inmux;
    logic        bubble;
    logic [1:0]  state;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [3:0]  scnt4;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycle_no = 0;
  logic [15:0] m_scnt   = 16'd0;
  logic [15:0] m_fcnt   = 16'd0;
  logic [3:0]  m_scnt4  = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cycle_no, act, exp);
    end
  endtask

  // driver: one clock cycle of inputs plus the hand-derived expected strobes/state
  task automatic cyc(input logic r, input logic mr, input logic [4:0] ert,
                     input logic [4:0] irs, input logic [4:0] irt, input logic ur,
                     input logic b, input logic [31:0] tgt, input logic h,
                     input logic es, input logic ep, input logic eb,
                     input logic [1:0] est);
    exp_t e;
    @(negedge clk);
    rst = r; ex_mem_read = mr; ex_rt = ert; id_rs = irs; id_rt = irt;
    id_uses_rt = ur; branch_taken = b; branch_target = tgt; hold_req = h;
    e.stall  = es;
    e.pcsrc  = ep;
    e.inmux  = ep ? tgt : 32'd0;
    e.bubble = eb;
    e.state  = est;
    e.scnt   = r ? 16'd0 : m_scnt;
    e.fcnt   = r ? 16'd0 : m_fcnt;
    e.scnt4  = r ? 4'd0  : m_scnt4;
    exp_q.push_back(e);
    if (r) begin
      m_scnt = 16'd0; m_fcnt = 16'd0; m_scnt4 = 4'd0;
    end else begin
      if (es) begin
        m_scnt = m_scnt + 16'd1;
        if (m_scnt4 != 4'd15) m_scnt4 = m_scnt4 + 4'd1;
      end
      if (ep) m_fcnt = m_fcnt + 16'd1;
    end
  endtask

  task automatic idle(input logic [1:0] est);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, est);
  endtask

  task automatic hold_cyc(input logic [1:0] est);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 1, 1, 0, 1, est);
  endtask

  task automatic do_reset();
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 2'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",       {31'd0, stall},  {31'd0, e.stall});
      chk("pcsrc",       {31'd0, pcsrc},  {31'd0, e.pcsrc});
      chk("inmux",       in_mux,          e.inmux);
      chk("bubble",      {31'd0, bubble}, {31'd0, e.bubble});
      chk("state",       {30'd0, state},  {30'd0, e.state});
      chk("stall_count", {16'd0, stall_cnt}, {16'd0, e.scnt});
      chk("flush_count", {16'd0, flush_cnt}, {16'd0, e.fcnt});
      chk("stall_count4", {28'd0, stall_cnt4}, {28'd0, e.scnt4});
      cycle_no++;
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt = '0; branch_taken = 1'b0; branch_target = '0; hold_req = 1'b0;

    // reset with a hazard and hold present: outputs must still read zero
    do_reset();
    cyc(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 32'd0, 1, 0, 0, 0, 2'd0);

    // load-use on rs held two cycles: exactly one stall cycle
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 32'd0, 0, 1, 0, 1, 2'd0);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 2'd1);
    idle(2'd0);

    // zero register never hazards; rt only counts when it is a source
    cyc(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 2'd0);
    cyc(0, 1, 5'd9, 5'd0, 5'd9, 0, 0, 32'd0, 0, 0, 0, 0, 2'd0);
    cyc(0, 1, 5'd9, 5'd0, 5'd9, 1, 0, 32'd0, 0, 1, 0, 1, 2'd0);
    idle(2'd1);
    idle(2'd0);

    // branch beats a simultaneous load-use; hazard ignored in REDIRECT
    do_reset();
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 32'h0000_0040, 0, 0, 1, 1, 2'd0);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 2'd3);
    idle(2'd0);

    // back-to-back redirects, each one flushes
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'h0000_1000, 0, 0, 1, 1, 2'd0);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'h0000_2004, 0, 0, 1, 1, 2'd3);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 1, 2'd3);
    idle(2'd3);
    idle(2'd0);

    // plain five-cycle hold
    do_reset();
    hold_cyc(2'd0);
    for (int i = 0; i < 4; i++) hold_cyc(2'd2);
    idle(2'd2);
    idle(2'd0);

    // hold with a branch in its third cycle: redirect wins, hold resumes
    do_reset();
    hold_cyc(2'd0);
    hold_cyc(2'd2);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'h0000_0080, 1, 0, 1, 1, 2'd2);
    hold_cyc(2'd3);
    hold_cyc(2'd2);
    idle(2'd2);
    idle(2'd0);

    // twenty-cycle hold: the 4-bit counter sticks at 15
    do_reset();
    hold_cyc(2'd0);
    for (int i = 0; i < 19; i++) hold_cyc(2'd2);
    idle(2'd2);
    idle(2'd0);

    // reset in the middle of a hold drops it completely
    hold_cyc(2'd0);
    hold_cyc(2'd2);
    hold_cyc(2'd2);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 1, 0, 0, 0, 2'd0);
    idle(2'd0);

    @(negedge clk);
    #5;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_controller.md
# fetch_hazard_controller

Pipeline control unit that sequences the instruction fetch stage of the 5-stage MIPS pipeline. It detects load-use hazards, external fetch holds and taken branches/jumps, and drives the fetch stage's `Stall`, `PCsrc` and `inMux` inputs. It also drives a bubble-insert strobe to the ID/EX register and keeps saturating stall and flush performance counters. It sits beside the ID stage and takes hazard information from IF/ID, ID/EX and the branch-resolution logic.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IDrs` in 5: rs field of the instruction in IF/ID.
- `IDrt` in 5: rt field of the instruction in IF/ID.
- `IDusesRt` in 1: the IF/ID instruction reads rt as a source.
- `EXMemRead` in 1: the ID/EX instruction is a load.
- `EXrt` in 5: destination register of the ID/EX load.
- `BranchTaken` in 1: a branch or jump resolved taken this cycle.
- `BranchTarget` in 32: redirect address, valid when `BranchTaken`=1.
- `HoldReq` in 1: external request to freeze fetch (loader/debug).
- `Stall` out 1: freezes the PC and IF/ID.
- `PCsrc` out 1: redirects the PC to `inMux` and zeroes IF/ID.
- `inMux` out 32: redirect target.
- `IDEXBubble` out 1: loads all-zero control into ID/EX next edge.
- `StallCount` out CNT_W: number of cycles with `Stall`=1.
- `FlushCount` out CNT_W: number of cycles with `PCsrc`=1.
- `State` out 2: FSM state, for debug (RUN=0, LUSTALL=1, HOLD=2, REDIRECT=3).

## Operation
- FSM states:
  - RUN: normal fetch.
  - LUSTALL: the single load-use stall cycle has just been issued.
  - HOLD: external freeze is active.
  - REDIRECT: first cycle after a redirect; IF/ID holds a zeroed instruction.
- Load-use hit (`luhit`) = `EXMemRead` & (`EXrt`≠0) & ((`EXrt`==`IDrs`) | (`IDusesRt` & `EXrt`==`IDrt`)).
- Priority, highest first: `RST` > `BranchTaken` > `HoldReq` > `luhit`.
- `BranchTaken`=1, in any state:
  - Outputs: `PCsrc`=1, `inMux`=`BranchTarget`, `Stall`=0, `IDEXBubble`=1.
  - Next state: REDIRECT.
- Else `HoldReq`=1:
  - Outputs: `Stall`=1, `IDEXBubble`=1.
  - Next state: HOLD.
- Else `luhit`=1 and state is RUN:
  - Outputs: `Stall`=1, `IDEXBubble`=1.
  - Next state: LUSTALL.
- Else: `Stall`=0, `PCsrc`=0, `IDEXBubble`=0; next state RUN.
- In LUSTALL, REDIRECT and HOLD (with `HoldReq` low), `luhit` is ignored. This caps a load-use stall at exactly one cycle, and the zeroed IF/ID instruction cannot raise a false hazard.
- `inMux` = 0 whenever `PCsrc`=0.
- Counters:
  - Each counter increments by 1 on every edge where its strobe (`Stall` or `PCsrc`) was 1.
  - Each saturates at 2^CNT_W−1; no wrap.
  - Both cleared only by `RST`.

## Timing
- `Stall`, `PCsrc`, `inMux` and `IDEXBubble` are combinational from the inputs and the registered state. They take effect at the next rising edge.
- Reset: while `RST`=1, all outputs are forced to 0. On that edge, the state becomes RUN and both counters become 0. Reset asserted mid-stall or mid-hold aborts it with no pending work retained.
- Latency: from a hazard input to the control strobe is 0 cycles.
- A load-use stall lasts exactly 1 cycle. HOLD lasts as long as `HoldReq` stays high; fetch resumes in the first cycle `HoldReq` is low.
- Simultaneous `BranchTaken` with `HoldReq` or `luhit`:
  - The redirect wins.
  - `Stall`=0 that cycle, and `StallCount` does not increment.
  - If `HoldReq` is still high the next cycle, the state enters HOLD from REDIRECT.
- Back-to-back `BranchTaken`: each cycle redirects; `FlushCount` increments each cycle.

## Test plan
- Reset then load-use: reset, then `EXMemRead`=1, `EXrt`=8, `IDrs`=8 for 2 cycles → `Stall`=`IDEXBubble`=1 for exactly 1 cycle, state RUN→LUSTALL→RUN, `StallCount`=1.
- Zero-register and rt-unused cases:
  - `EXrt`=0=`IDrs` → no stall.
  - `EXrt`=9=`IDrt` with `IDusesRt`=0 → no stall.
  - Same with `IDusesRt`=1 → 1-cycle stall.
- Branch beats hazard: `BranchTaken`=1, `BranchTarget`=0x0000_0040, with `luhit` true → `PCsrc`=1, `inMux`=0x40, `Stall`=0, state REDIRECT next, `FlushCount`=1, `StallCount` unchanged.
- Hold: `HoldReq` high for 5 cycles → `Stall`=1 for 5 cycles, state HOLD, `StallCount`=5. A `BranchTaken` in the 3rd cycle gives `PCsrc`=1, `Stall`=0 that cycle and HOLD resumed after; the final count is `StallCount`=4.
- Saturation: with `CNT_W`=4, hold `HoldReq` for 20 cycles → `StallCount` sticks at 15.
- Reset mid-hold: `HoldReq`=1 for 3 cycles, then assert `RST` → outputs 0 while asserted, then state RUN and counters 0 after the edge.
